// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control/status bundle between the multi-cycle sequencer and the datapath
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       im_ready;
  logic       dm_ready;
  logic       im_req;
  logic       dm_req;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       grf_we;
  logic       dm_we;
  logic [2:0] alu_op;
  logic [1:0] ext_op;
  logic       alu_b_sel;
  logic [1:0] grf_a3_sel;
  logic [1:0] grf_wd_sel;
  logic       retire;
  logic       illegal;
  modport master (
    input  opcode, funct, zero, im_ready, dm_ready,
    output im_req, dm_req, ir_we, pc_we, pc_sel, grf_we, dm_we, alu_op, ext_op,
           alu_b_sel, grf_a3_sel, grf_wd_sel, retire, illegal
  );
  modport slave (
    output opcode, funct, zero, im_ready, dm_ready,
    input  im_req, dm_req, ir_we, pc_we, pc_sel, grf_we, dm_we, alu_op, ext_op,
           alu_b_sel, grf_a3_sel, grf_wd_sel, retire, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the MIPS subset datapath
module mc_ctrl (
  input logic       clk,
  input logic       reset,
  mc_ctrl_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [3:0] {C_NOP, C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_JR, C_ILL} cls_t;
  state_t     state_q, state_d;
  logic [5:0] op_q, op_d, fn_q, fn_d;
  cls_t       cls;
  always_comb begin
    cls = C_ILL;
    case (op_q)
      6'h00: cls = fn_q == 6'h21 ? C_ADDU : fn_q == 6'h23 ? C_SUBU :
                   fn_q == 6'h08 ? C_JR   : fn_q == 6'h00 ? C_NOP  : C_ILL;
      6'h0d: cls = C_ORI;
      6'h0f: cls = C_LUI;
      6'h23: cls = C_LW;
      6'h2b: cls = C_SW;
      6'h04: cls = C_BEQ;
      6'h03: cls = C_JAL;
      default: cls = C_ILL;
    endcase
  end
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    fn_d           = fn_q;
    bus.im_req     = 1'b0;
    bus.dm_req     = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.pc_sel     = 2'd0;
    bus.grf_we     = 1'b0;
    bus.dm_we      = 1'b0;
    bus.alu_op     = 3'd0;
    bus.ext_op     = 2'd0;
    bus.alu_b_sel  = 1'b0;
    bus.grf_a3_sel = 2'd0;
    bus.grf_wd_sel = 2'd0;
    bus.retire     = 1'b0;
    bus.illegal    = 1'b0;
    // ALU-path selects are set in EXEC and held through MEM and WB
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      bus.alu_op    = (cls == C_SUBU || cls == C_BEQ) ? 3'd1 : cls == C_ORI ? 3'd2 : 3'd0;
      bus.ext_op    = cls == C_LUI ? 2'd2 : (cls == C_LW || cls == C_SW || cls == C_BEQ) ? 2'd1 : 2'd0;
      bus.alu_b_sel = cls == C_ORI || cls == C_LW || cls == C_SW;
    end
    case (state_q)
      FETCH: begin
        bus.im_req = 1'b1;
        bus.ir_we  = bus.im_ready;
        bus.pc_we  = bus.im_ready;
        if (bus.im_ready) begin
          op_d    = bus.opcode;
          fn_d    = bus.funct;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (cls == C_NOP || cls == C_ILL) begin
          bus.retire  = 1'b1;
          bus.illegal = cls == C_ILL;
          state_d     = FETCH;
        end else state_d = EXEC;
      end
      EXEC: begin
        if (cls == C_BEQ) begin
          bus.pc_we  = bus.zero;
          bus.pc_sel = 2'd1;
          bus.retire = 1'b1;
          state_d    = FETCH;
        end else if (cls == C_JAL) begin
          bus.grf_we     = 1'b1;
          bus.grf_a3_sel = 2'd2;
          bus.grf_wd_sel = 2'd3;
          bus.pc_we      = 1'b1;
          bus.pc_sel     = 2'd2;
          bus.retire     = 1'b1;
          state_d        = FETCH;
        end else if (cls == C_JR) begin
          bus.pc_we  = 1'b1;
          bus.pc_sel = 2'd3;
          bus.retire = 1'b1;
          state_d    = FETCH;
        end else state_d = (cls == C_LW || cls == C_SW) ? MEM : WB;
      end
      MEM: begin
        bus.dm_req = 1'b1;
        bus.dm_we  = cls == C_SW;
        if (bus.dm_ready) begin
          bus.retire = cls == C_SW;
          state_d    = cls == C_SW ? FETCH : WB;
        end
      end
      WB: begin
        bus.grf_we     = 1'b1;
        bus.grf_a3_sel = (cls == C_ADDU || cls == C_SUBU) ? 2'd0 : 2'd1;
        bus.grf_wd_sel = cls == C_LUI ? 2'd2 : cls == C_LW ? 2'd1 : 2'd0;
        bus.retire     = 1'b1;
        state_d        = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed table, hand sequences and randomized instruction stream for mc_ctrl
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mc_ctrl_if bus();
  mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_ORI = 3, K_LUI = 4, K_LW = 5,
                 K_SW = 6, K_BEQ = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;
  logic [19:0] o;
  assign o = {bus.im_req, bus.dm_req, bus.ir_we, bus.pc_we, bus.pc_sel, bus.grf_we, bus.dm_we,
              bus.alu_op, bus.ext_op, bus.alu_b_sel, bus.grf_a3_sel, bus.grf_wd_sel,
              bus.retire, bus.illegal};
  typedef struct {
    int cyc, nim, npc, ngrf, ndm, ndmwe, nill, bad;
    logic [1:0] a3, wd, xsel, ext;
    logic [2:0] aop;
    logic       bsel;
  } stats_t;
  typedef struct {
    logic [5:0] op, fn;
    logic       z;
    int imw, dmw, cyc, npc, ngrf, ndm, ndmwe, nill;
  } vec_t;
  int errs = 0, checks = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic step(input logic imr, input logic dmr, input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk);
    bus.im_ready = imr;
    bus.dm_ready = dmr;
    bus.opcode   = op;
    bus.funct    = fn;
    #1;
  endtask
  // Drives one instruction with the given memory wait counts and collects per-instruction tallies
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int imw, input int dmw, output stats_t s);
    int imc = 0, dmc = 0;
    logic imr, dmr;
    bit done = 0;
    s = '{default: 0};
    while (!done && s.cyc < 40) begin
      @(negedge clk);
      imr = bus.im_req ? 1'(imc == imw) : 1'($urandom);
      dmr = bus.dm_req ? 1'(dmc == dmw) : 1'($urandom);
      if (bus.im_req) imc++;
      if (bus.dm_req) dmc++;
      bus.im_ready = imr;
      bus.dm_ready = dmr;
      bus.zero     = z;
      bus.opcode   = imr ? op : 6'($urandom);
      bus.funct    = imr ? fn : 6'($urandom);
      #1;
      s.cyc++;
      s.nim   += int'(o[19]);
      s.ndm   += int'(o[18]);
      s.npc   += int'(o[16]);
      s.ngrf  += int'(o[13]);
      s.ndmwe += int'(o[12]);
      s.nill  += int'(o[0]);
      if (o[13]) begin s.a3 = o[5:4]; s.wd = o[3:2]; end
      if (o[16] && !o[17]) s.xsel = o[15:14];
      if (o[17] && (o[15:14] != 2'd0 || !o[16])) s.bad++;
      if (o[12] && !o[18]) s.bad++;
      if (o[1]) begin
        done   = 1;
        s.aop  = o[11:9];
        s.ext  = o[8:7];
        s.bsel = o[6];
      end
    end
    if (!done) begin
      s.cyc = 99;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
    end
  endtask
  function automatic stats_t model(input int k, input logic z, input int imw, input int dmw);
    stats_t e = '{default: 0};
    bit mem = k == K_LW || k == K_SW;
    e.cyc   = ((k == K_NOP || k == K_ILL) ? 2 : (k == K_BEQ || k == K_JAL || k == K_JR) ? 3 :
               k == K_LW ? 5 : 4) + imw + (mem ? dmw : 0);
    e.nim   = imw + 1;
    e.npc   = 1 + ((k == K_JAL || k == K_JR || (k == K_BEQ && z)) ? 1 : 0);
    e.ngrf  = (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_JAL}) ? 1 : 0;
    e.a3    = k == K_JAL ? 2'd2 : (k inside {K_ORI, K_LUI, K_LW}) ? 2'd1 : 2'd0;
    e.wd    = k == K_JAL ? 2'd3 : k == K_LUI ? 2'd2 : k == K_LW ? 2'd1 : 2'd0;
    e.xsel  = k == K_JR ? 2'd3 : k == K_JAL ? 2'd2 : (k == K_BEQ && z) ? 2'd1 : 2'd0;
    e.ndm   = mem ? dmw + 1 : 0;
    e.ndmwe = k == K_SW ? dmw + 1 : 0;
    e.nill  = k == K_ILL ? 1 : 0;
    e.aop   = (k == K_SUBU || k == K_BEQ) ? 3'd1 : k == K_ORI ? 3'd2 : 3'd0;
    e.ext   = k == K_LUI ? 2'd2 : (k inside {K_LW, K_SW, K_BEQ}) ? 2'd1 : 2'd0;
    e.bsel  = k inside {K_ORI, K_LW, K_SW};
    return e;
  endfunction
  task automatic enc(input int k, output logic [5:0] op, output logic [5:0] fn);
    int r;
    fn = 6'($urandom);
    case (k)
      K_NOP:  begin op = 6'h00; fn = 6'h00; end
      K_ADDU: begin op = 6'h00; fn = 6'h21; end
      K_SUBU: begin op = 6'h00; fn = 6'h23; end
      K_JR:   begin op = 6'h00; fn = 6'h08; end
      K_ORI:  op = 6'h0d;
      K_LUI:  op = 6'h0f;
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2b;
      K_BEQ:  op = 6'h04;
      K_JAL:  op = 6'h03;
      default: begin
        r  = $urandom_range(0, 3);
        op = r == 0 ? 6'h3f : r == 1 ? 6'h02 : r == 2 ? 6'h08 : 6'h00;
        if (op == 6'h00) fn = r[0] ? 6'h20 : 6'h25;
      end
    endcase
  endtask
  vec_t tv[15];
  stats_t s, e;
  logic [5:0] rop, rfn;
  logic rz;
  int k, imw, dmw;
  initial begin
    tv[0]  = '{6'h00, 6'h21, 1'b0, 0, 0, 4, 1, 1, 0, 0, 0};
    tv[1]  = '{6'h23, 6'h05, 1'b0, 0, 2, 7, 1, 1, 3, 0, 0};
    tv[2]  = '{6'h2b, 6'h11, 1'b0, 0, 0, 4, 1, 0, 1, 1, 0};
    tv[3]  = '{6'h04, 6'h00, 1'b1, 0, 0, 3, 2, 0, 0, 0, 0};
    tv[4]  = '{6'h04, 6'h00, 1'b0, 0, 0, 3, 1, 0, 0, 0, 0};
    tv[5]  = '{6'h03, 6'h3f, 1'b0, 0, 0, 3, 2, 1, 0, 0, 0};
    tv[6]  = '{6'h00, 6'h08, 1'b0, 0, 0, 3, 2, 0, 0, 0, 0};
    tv[7]  = '{6'h3f, 6'h00, 1'b0, 0, 0, 2, 1, 0, 0, 0, 1};
    tv[8]  = '{6'h00, 6'h00, 1'b0, 0, 0, 2, 1, 0, 0, 0, 0};
    tv[9]  = '{6'h0d, 6'h3f, 1'b0, 2, 0, 6, 1, 1, 0, 0, 0};
    tv[10] = '{6'h0f, 6'h00, 1'b0, 1, 0, 5, 1, 1, 0, 0, 0};
    tv[11] = '{6'h2b, 6'h01, 1'b0, 1, 3, 8, 1, 0, 4, 4, 0};
    tv[12] = '{6'h00, 6'h23, 1'b0, 0, 0, 4, 1, 1, 0, 0, 0};
    tv[13] = '{6'h00, 6'h20, 1'b0, 0, 0, 2, 1, 0, 0, 0, 1};
    tv[14] = '{6'h23, 6'h00, 1'b0, 2, 0, 7, 1, 1, 1, 0, 0};
    bus.im_ready = 1'b0;
    bus.dm_ready = 1'b0;
    bus.zero     = 1'b0;
    bus.opcode   = 6'h00;
    bus.funct    = 6'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_outs", 32'(o), 32'h80000);
    step(1'b1, 1'b0, 6'h00, 6'h21); chk("addu_c0", 32'(o), 32'hB0000);
    step(1'b0, 1'b0, 6'h00, 6'h21); chk("addu_c1", 32'(o), 32'h00000);
    step(1'b0, 1'b0, 6'h00, 6'h21); chk("addu_c2", 32'(o), 32'h00000);
    step(1'b0, 1'b0, 6'h00, 6'h21); chk("addu_c3", 32'(o), 32'h02002);
    step(1'b0, 1'b0, 6'h00, 6'h21); chk("addu_c4", 32'(o), 32'h80000);
    step(1'b1, 1'b0, 6'h23, 6'h00);
    step(1'b0, 1'b0, 6'h00, 6'h00);
    step(1'b0, 1'b0, 6'h00, 6'h00);
    step(1'b0, 1'b0, 6'h00, 6'h00); chk("mem_wait_dm_req", 32'(o[18]), 32'h1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; bus.dm_ready = 1'b0; bus.im_ready = 1'b0;
    #1;
    chk("reset_in_mem", 32'(o), 32'h80000);
    for (int i = 0; i < 15; i++) begin
      run_instr(tv[i].op, tv[i].fn, tv[i].z, tv[i].imw, tv[i].dmw, s);
      chk($sformatf("tv%0d_cyc", i), 32'(s.cyc), 32'(tv[i].cyc));
      chk($sformatf("tv%0d_pc_we", i), 32'(s.npc), 32'(tv[i].npc));
      chk($sformatf("tv%0d_grf_we", i), 32'(s.ngrf), 32'(tv[i].ngrf));
      chk($sformatf("tv%0d_dm_req", i), 32'(s.ndm), 32'(tv[i].ndm));
      chk($sformatf("tv%0d_dm_we", i), 32'(s.ndmwe), 32'(tv[i].ndmwe));
      chk($sformatf("tv%0d_illegal", i), 32'(s.nill), 32'(tv[i].nill));
    end
    for (int i = 0; i < 300; i++) begin
      k   = $urandom_range(0, 10);
      rz  = 1'($urandom);
      imw = $urandom_range(0, 2);
      dmw = $urandom_range(0, 2);
      enc(k, rop, rfn);
      run_instr(rop, rfn, rz, imw, dmw, s);
      e = model(k, rz, imw, dmw);
      chk($sformatf("r%0d_k%0d_cyc", i, k), 32'(s.cyc), 32'(e.cyc));
      chk($sformatf("r%0d_k%0d_im_req", i, k), 32'(s.nim), 32'(e.nim));
      chk($sformatf("r%0d_k%0d_pc_we", i, k), 32'(s.npc), 32'(e.npc));
      chk($sformatf("r%0d_k%0d_grf_we", i, k), 32'(s.ngrf), 32'(e.ngrf));
      chk($sformatf("r%0d_k%0d_wb_sel", i, k), 32'({s.a3, s.wd}), 32'({e.a3, e.wd}));
      chk($sformatf("r%0d_k%0d_pc_sel", i, k), 32'(s.xsel), 32'(e.xsel));
      chk($sformatf("r%0d_k%0d_dm", i, k), 32'({s.ndm[7:0], s.ndmwe[7:0]}), 32'({e.ndm[7:0], e.ndmwe[7:0]}));
      chk($sformatf("r%0d_k%0d_illegal", i, k), 32'(s.nill), 32'(e.nill));
      chk($sformatf("r%0d_k%0d_alu_sel", i, k), 32'({s.aop, s.ext, s.bsel}), 32'({e.aop, e.ext, e.bsel}));
      chk($sformatf("r%0d_k%0d_protocol", i, k), 32'(s.bad), 32'h0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
